// File: rtl/ram_arb_pkg.sv
// Shared defaults and types for the two-requester RAM port arbiter.
package ram_arb_pkg;

  localparam int unsigned ADDR_WIDTH = 5;
  localparam int unsigned DATA_WIDTH = 32;

  typedef logic req_id_t;

  typedef struct packed {
    logic    valid;
    req_id_t owner;
  } rd_pend_t;

  function automatic logic [1:0] id_onehot(req_id_t id);
    return id ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/ram_port_arbiter_if.sv
// Requester-side and RAM-side signal bundle for ram_port_arbiter.
// slave: arbiter view; master: requesters plus RAM view.
interface ram_port_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = ram_arb_pkg::ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = ram_arb_pkg::DATA_WIDTH
);

  logic                  ren_0;
  logic [ADDR_WIDTH-1:0] raddr_0;
  logic                  wen_0;
  logic [ADDR_WIDTH-1:0] waddr_0;
  logic [DATA_WIDTH-1:0] wdata_0;
  logic [DATA_WIDTH-1:0] rdata_0;
  logic                  rvalid_0;
  logic                  stall_0;

  logic                  ren_1;
  logic [ADDR_WIDTH-1:0] raddr_1;
  logic                  wen_1;
  logic [ADDR_WIDTH-1:0] waddr_1;
  logic [DATA_WIDTH-1:0] wdata_1;
  logic [DATA_WIDTH-1:0] rdata_1;
  logic                  rvalid_1;
  logic                  stall_1;

  logic [ADDR_WIDTH-1:0] mem_raddr;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_wen;

  modport slave (
    input  ren_0, raddr_0, wen_0, waddr_0, wdata_0,
    input  ren_1, raddr_1, wen_1, waddr_1, wdata_1,
    input  mem_rdata,
    output rdata_0, rvalid_0, stall_0,
    output rdata_1, rvalid_1, stall_1,
    output mem_raddr, mem_waddr, mem_wdata, mem_wen
  );

  modport master (
    output ren_0, raddr_0, wen_0, waddr_0, wdata_0,
    output ren_1, raddr_1, wen_1, waddr_1, wdata_1,
    output mem_rdata,
    input  rdata_0, rvalid_0, stall_0,
    input  rdata_1, rvalid_1, stall_1,
    input  mem_raddr, mem_waddr, mem_wdata, mem_wen
  );

endinterface

// File: rtl/ram_arb_grant.sv
// Combinational round-robin grant: which requesters issue this cycle and
// which of them owns the RAM read and write ports.
module ram_arb_grant
  import ram_arb_pkg::*;
(
  input  req_id_t    prio,
  input  logic [1:0] ren,
  input  logic [1:0] wen,
  input  logic       block,
  output logic [1:0] active,
  output logic [1:0] issued,
  output logic       rd_gnt,
  output req_id_t    rd_owner,
  output logic       wr_gnt,
  output req_id_t    wr_owner
);

  req_id_t other;
  logic    overlap;

  assign active  = ren | wen;
  assign other   = ~prio;
  assign overlap = (ren[other] & ren[prio]) | (wen[other] & wen[prio]);

  always_comb begin
    issued = 2'b00;
    if (!block) begin
      issued[prio]  = active[prio];
      issued[other] = active[other] & ~overlap;
    end
  end

  // Overlapping requests never both issue, so each mask keeps at most one bit.
  assign rd_gnt   = |(issued & ren);
  assign rd_owner = issued[1] & ren[1];
  assign wr_gnt   = |(issued & wen);
  assign wr_owner = issued[1] & wen[1];

endmodule

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one 1-cycle-latency RAM between two requesters.
// Define RAM_ARB_PERF_EN to add saturating per-requester conflict counters.
module ram_port_arbiter #(
  parameter int unsigned ADDR_WIDTH = ram_arb_pkg::ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = ram_arb_pkg::DATA_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               global_stall,
  ram_port_arbiter_if.slave  bus
`ifdef RAM_ARB_PERF_EN
  ,
  output logic [15:0]        conflict_cnt_0,
  output logic [15:0]        conflict_cnt_1
`endif
);
  import ram_arb_pkg::*;

  logic [1:0]            ren, wen, active, issued, stall, hold_block;
  logic [1:0]            ret, rvalid, hold_valid_d, hold_valid_q;
  logic [ADDR_WIDTH-1:0] raddr [2];
  logic [ADDR_WIDTH-1:0] waddr [2];
  logic [DATA_WIDTH-1:0] wdata [2];
  logic [DATA_WIDTH-1:0] rdata [2];
  logic [DATA_WIDTH-1:0] hold_d [2];
  logic [DATA_WIDTH-1:0] hold_q [2];
  logic                  block, rd_gnt, wr_gnt;
  req_id_t               prio_d, prio_q, rd_owner, wr_owner;
  rd_pend_t              pend_d, pend_q;

  assign ren      = {bus.ren_1, bus.ren_0};
  assign wen      = {bus.wen_1, bus.wen_0};
  assign raddr[0] = bus.raddr_0;
  assign raddr[1] = bus.raddr_1;
  assign waddr[0] = bus.waddr_0;
  assign waddr[1] = bus.waddr_1;
  assign wdata[0] = bus.wdata_0;
  assign wdata[1] = bus.wdata_1;

  // Reset suppresses issue exactly like an external freeze.
  assign block      = rst | global_stall;
  assign hold_block = 2'b00;

  ram_arb_grant u_grant (
    .prio     (prio_q),
    .ren      (ren),
    .wen      (wen),
    .block    (block),
    .active   (active),
    .issued   (issued),
    .rd_gnt   (rd_gnt),
    .rd_owner (rd_owner),
    .wr_gnt   (wr_gnt),
    .wr_owner (wr_owner)
  );

  assign stall = {2{block}} | (active & ~issued) | hold_block;

  assign bus.mem_raddr = rd_gnt ? raddr[rd_owner] : '0;
  assign bus.mem_waddr = wr_gnt ? waddr[wr_owner] : '0;
  assign bus.mem_wdata = wr_gnt ? wdata[wr_owner] : '0;
  assign bus.mem_wen   = wr_gnt;

  assign prio_d = issued[prio_q] ? ~prio_q : prio_q;

  assign ret = pend_q.valid ? id_onehot(pend_q.owner) : 2'b00;

  always_comb begin
    pend_d.valid = rd_gnt;
    pend_d.owner = rd_owner;
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    for (int i = 0; i < 2; i++) begin
      // hold_q always latches the returned word so rdata keeps its last value.
      if (ret[i]) begin
        hold_d[i]       = bus.mem_rdata;
        hold_valid_d[i] = stall[i];
      end else if (!stall[i]) begin
        hold_valid_d[i] = 1'b0;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      rvalid[i] = ~rst & (ret[i] | hold_valid_q[i]);
      rdata[i]  = ret[i] ? bus.mem_rdata : hold_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prio_q       <= 1'b0;
      pend_q       <= '0;
      hold_q       <= '{default: '0};
      hold_valid_q <= 2'b00;
    end else begin
      prio_q       <= prio_d;
      pend_q       <= pend_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
    end
  end

  assign bus.rdata_0  = rdata[0];
  assign bus.rdata_1  = rdata[1];
  assign bus.rvalid_0 = rvalid[0];
  assign bus.rvalid_1 = rvalid[1];
  assign bus.stall_0  = stall[0];
  assign bus.stall_1  = stall[1];

`ifdef RAM_ARB_PERF_EN
  logic [1:0]  conflict;
  logic [15:0] cnt_q [2];

  assign conflict = active & ~issued & {2{~global_stall}};

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '{default: '0};
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (conflict[i] && (cnt_q[i] != 16'hFFFF)) begin
          cnt_q[i] <= cnt_q[i] + 16'd1;
        end
      end
    end
  end

  assign conflict_cnt_0 = cnt_q[0];
  assign conflict_cnt_1 = cnt_q[1];
`endif

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Scoreboarded bench for ram_port_arbiter with a behavioural 1-cycle RAM.
// Covers the RAM_ARB_PERF_EN counters when that macro is defined.
module tb_ram_port_arbiter;

  logic clk, rst, global_stall;
  int   n_vec, n_err;

  ram_port_arbiter_if bus ();

`ifdef RAM_ARB_PERF_EN
  logic [15:0] conflict_cnt_0, conflict_cnt_1;
`endif

  ram_port_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .global_stall (global_stall),
    .bus          (bus)
`ifdef RAM_ARB_PERF_EN
    ,
    .conflict_cnt_0 (conflict_cnt_0),
    .conflict_cnt_1 (conflict_cnt_1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural RAM with a side preload port.
  logic [31:0] ram    [32];
  logic [31:0] shadow [32];
  logic        pl_en;
  logic [4:0]  pl_addr;
  logic [31:0] pl_data;

  always @(posedge clk) begin
    if (pl_en) ram[pl_addr] <= pl_data;
    else if (bus.mem_wen) ram[bus.mem_waddr] <= bus.mem_wdata;
    bus.mem_rdata <= ram[bus.mem_raddr];
  end

  logic [31:0] exp_q0 [$];
  logic [31:0] exp_q1 [$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // A word is consumed when it is valid and its owner is not stalled.
  always @(negedge clk) begin
    if (bus.rvalid_0 && !bus.stall_0) begin
      if (exp_q0.size() == 0) check_val("ret0_unexpected", 32'(exp_q0.size()), 32'd1);
      else check_val("ret0_data", bus.rdata_0, exp_q0.pop_front());
    end
    if (bus.rvalid_1 && !bus.stall_1) begin
      if (exp_q1.size() == 0) check_val("ret1_unexpected", 32'(exp_q1.size()), 32'd1);
      else check_val("ret1_data", bus.rdata_1, exp_q1.pop_front());
    end
  end

  task automatic set_req(input int i, input logic ren, input logic [4:0] ra, input logic wen,
                         input logic [4:0] wa, input logic [31:0] wd);
    if (i == 0) begin
      bus.ren_0 = ren; bus.raddr_0 = ra; bus.wen_0 = wen; bus.waddr_0 = wa; bus.wdata_0 = wd;
    end else begin
      bus.ren_1 = ren; bus.raddr_1 = ra; bus.wen_1 = wen; bus.waddr_1 = wa; bus.wdata_1 = wd;
    end
  endtask

  task automatic idle();
    set_req(0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0);
    set_req(1, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic rd(input int i, input logic [4:0] a);
    set_req(i, 1'b1, a, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic preload(input logic [4:0] a, input logic [31:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d; shadow[a] = d;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    n_vec = 0; n_err = 0;
    rst = 1'b1; global_stall = 1'b0; pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    idle();
    tick();

    // Reset state, preloading the RAM meanwhile.
    preload(5'd1, 32'd10);
    rd(0, 5'd1);
    set_req(1, 1'b0, 5'd0, 1'b1, 5'd6, 32'd3);
    sample();
    check_val("rst_stall0", 32'(bus.stall_0), 32'd1);
    check_val("rst_stall1", 32'(bus.stall_1), 32'd1);
    check_val("rst_rvalid0", 32'(bus.rvalid_0), 32'd0);
    check_val("rst_rvalid1", 32'(bus.rvalid_1), 32'd0);
    check_val("rst_mem_wen", 32'(bus.mem_wen), 32'd0);
    check_val("rst_mem_raddr", 32'(bus.mem_raddr), 32'd0);
    tick();
    idle();
    preload(5'd2, 32'd20);
    tick();
    pl_en = 1'b0; rst = 1'b0;
    tick();

    // Uncontended read by requester 0.
    rd(0, 5'd1); exp_q0.push_back(shadow[1]);
    sample();
    check_val("t1_stall0", 32'(bus.stall_0), 32'd0);
    check_val("t1_mem_raddr", 32'(bus.mem_raddr), 32'd1);
    tick();
    idle();
    sample();
    check_val("t1_rvalid0", 32'(bus.rvalid_0), 32'd1);
    check_val("t1_rdata0", bus.rdata_0, 32'd10);
    tick();

    // Uncontended read by requester 1 returns priority to requester 0.
    rd(1, 5'd2); exp_q1.push_back(shadow[2]);
    sample();
    check_val("t1b_stall1", 32'(bus.stall_1), 32'd0);
    tick();
    idle();
    tick();

    // Read/read conflict with requester 0 holding priority.
    rd(0, 5'd1); rd(1, 5'd2); exp_q0.push_back(shadow[1]);
    sample();
    check_val("t2_stall0", 32'(bus.stall_0), 32'd0);
    check_val("t2_stall1", 32'(bus.stall_1), 32'd1);
    check_val("t2_raddr_a", 32'(bus.mem_raddr), 32'd1);
    tick();
    set_req(0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0); exp_q1.push_back(shadow[2]);
    sample();
    check_val("t2_stall1_b", 32'(bus.stall_1), 32'd0);
    check_val("t2_raddr_b", 32'(bus.mem_raddr), 32'd2);
    check_val("t2_rvalid0", 32'(bus.rvalid_0), 32'd1);
    tick();
    idle();
    sample();
    check_val("t2_rvalid1", 32'(bus.rvalid_1), 32'd1);
    check_val("t2_rdata1", bus.rdata_1, 32'd20);
    tick();
    // Priority must be back on requester 0.
    rd(0, 5'd2); rd(1, 5'd1); exp_q0.push_back(shadow[2]);
    sample();
    check_val("t2_prio_stall0", 32'(bus.stall_0), 32'd0);
    check_val("t2_prio_stall1", 32'(bus.stall_1), 32'd1);
    tick();
    set_req(0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0); exp_q1.push_back(shadow[1]);
    sample();
    check_val("t2_e_stall1", 32'(bus.stall_1), 32'd0);
    tick();

    // Disjoint ports: write by 0 alongside read by 1.
    set_req(0, 1'b0, 5'd0, 1'b1, 5'd3, 32'd5); rd(1, 5'd1);
    exp_q1.push_back(shadow[1]); shadow[3] = 32'd5;
    sample();
    check_val("t3_stall0", 32'(bus.stall_0), 32'd0);
    check_val("t3_stall1", 32'(bus.stall_1), 32'd0);
    check_val("t3_mem_wen", 32'(bus.mem_wen), 32'd1);
    check_val("t3_mem_waddr", 32'(bus.mem_waddr), 32'd3);
    check_val("t3_mem_wdata", bus.mem_wdata, 32'd5);
    check_val("t3_mem_raddr", 32'(bus.mem_raddr), 32'd1);
    tick();
    idle(); rd(0, 5'd3); exp_q0.push_back(shadow[3]);
    sample();
    check_val("t3_rd_stall0", 32'(bus.stall_0), 32'd0);
    tick();
    idle();
    sample();
    check_val("t3_rvalid0", 32'(bus.rvalid_0), 32'd1);
    tick();

    // Return captured across a 3-cycle global stall.
    rd(0, 5'd1); exp_q0.push_back(shadow[1]);
    sample();
    check_val("t4_stall0", 32'(bus.stall_0), 32'd0);
    tick();
    idle(); global_stall = 1'b1;
    set_req(1, 1'b0, 5'd0, 1'b1, 5'd4, 32'd99);
    for (int c = 0; c < 3; c++) begin
      sample();
      check_val("t4_gs_rvalid0", 32'(bus.rvalid_0), 32'd1);
      check_val("t4_gs_rdata0", bus.rdata_0, 32'd10);
      check_val("t4_gs_stall0", 32'(bus.stall_0), 32'd1);
      check_val("t4_gs_stall1", 32'(bus.stall_1), 32'd1);
      check_val("t4_gs_mem_wen", 32'(bus.mem_wen), 32'd0);
      tick();
    end
    global_stall = 1'b0;
    sample();
    check_val("t4_rel_rvalid0", 32'(bus.rvalid_0), 32'd1);
    check_val("t4_rel_stall1", 32'(bus.stall_1), 32'd0);
    check_val("t4_rel_mem_wen", 32'(bus.mem_wen), 32'd1);
    shadow[4] = 32'd99;
    tick();
    idle(); rd(0, 5'd4); exp_q0.push_back(shadow[4]);
    sample();
    check_val("t4_after_rvalid0", 32'(bus.rvalid_0), 32'd0);
    check_val("t4_after_stall0", 32'(bus.stall_0), 32'd0);
    tick();
    idle();
    tick();

    // Reset mid-read: the return is discarded.
    rd(0, 5'd2);
    tick();
    rst = 1'b1;
    set_req(1, 1'b0, 5'd0, 1'b1, 5'd5, 32'd7);
    sample();
    check_val("t5_rvalid0", 32'(bus.rvalid_0), 32'd0);
    check_val("t5_stall0", 32'(bus.stall_0), 32'd1);
    check_val("t5_stall1", 32'(bus.stall_1), 32'd1);
    check_val("t5_mem_wen", 32'(bus.mem_wen), 32'd0);
    check_val("t5_mem_raddr", 32'(bus.mem_raddr), 32'd0);
    check_val("t5_mem_waddr", 32'(bus.mem_waddr), 32'd0);
    check_val("t5_mem_wdata", bus.mem_wdata, 32'd0);
    tick();
    tick();
    rst = 1'b0; idle();
    sample();
    check_val("t5_post_rvalid0", 32'(bus.rvalid_0), 32'd0);
    tick();
    sample();
    check_val("t5_post2_rvalid0", 32'(bus.rvalid_0), 32'd0);
    tick();

`ifdef RAM_ARB_PERF_EN
    // Conflicts under global stall are not counted; two real conflicts are.
    global_stall = 1'b1; rd(0, 5'd1); rd(1, 5'd2);
    tick();
    tick();
    global_stall = 1'b0; exp_q0.push_back(shadow[1]);
    tick();
    set_req(0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0); exp_q1.push_back(shadow[2]);
    tick();
    rd(0, 5'd1); exp_q0.push_back(shadow[1]);
    tick();
    set_req(0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0); exp_q1.push_back(shadow[2]);
    tick();
    idle();
    sample();
    check_val("perf_sum", 32'(conflict_cnt_0) + 32'(conflict_cnt_1), 32'd2);
    tick();
`endif

    tick();
    tick();
    check_val("q0_drained", 32'(exp_q0.size()), 32'd0);
    check_val("q1_drained", 32'(exp_q1.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ram_port_arbiter.md
# ram_port_arbiter

Shares one RAM (separate 1-cycle-latency read port, single write port) between two HLS-generated requester modules. Grants each cycle's memory access round-robin and stalls the loser. Captures read data that returns while the issuing requester is stalled, so completed reads are never lost. Sits between the generated modules' `raddr_0/rdata_0/waddr_0/wdata_0/wen_0` ports and the `RAM` instance.

## Interface
- `ADDR_WIDTH`, 5, address width of both RAM ports.
- `DATA_WIDTH`, 32, data word width.

Ports (`i` in {0,1}; one set per requester):
- `clk`  in  1  clock; single clock domain.
- `rst`  in  1  reset, synchronous, active-high.
- `global_stall`  in  1  external freeze of the whole arbiter.
- `ren_i`  in  1  requester i read request.
- `raddr_i`  in  ADDR_WIDTH  requester i read address.
- `wen_i`  in  1  requester i write request.
- `waddr_i`  in  ADDR_WIDTH  requester i write address.
- `wdata_i`  in  DATA_WIDTH  requester i write data.
- `rdata_i`  out  DATA_WIDTH  returned read data to requester i.
- `rvalid_i`  out  1  `rdata_i` holds requester i's returned word.
- `stall_i`  out  1  requester i must hold state and requests this cycle.
- `mem_raddr`  out  ADDR_WIDTH  to RAM `raddr`.
- `mem_rdata`  in  DATA_WIDTH  from RAM `rdata`; valid 1 cycle after `mem_raddr`.
- `mem_waddr`  out  ADDR_WIDTH  to RAM `waddr`.
- `mem_wdata`  out  DATA_WIDTH  to RAM `wdata`.
- `mem_wen`  out  1  to RAM `wen`.

## Operation
- **Request and all-or-nothing issue**
  - Requester i is active when `ren_i | wen_i`.
  - An access issues only if every port it requests is granted. Otherwise nothing issues for it and `stall_i`=1.
- **Grant**
  - `prio` register (0/1) names the priority requester; it gets all requested ports.
  - The other requester is granted iff its requested ports do not overlap the priority requester's ports (read-only vs write-only both issue the same cycle).
- **Pointer update**
  - `prio` flips to the other requester after any cycle in which the priority requester issued.
  - Otherwise `prio` holds.
- **Stall**
  - `stall_i = global_stall | (active_i & !issued_i) | hold_block_i`.
  - `hold_block_i`: 0 in this revision (reserved).
- **Global stall**
  - No issue: `mem_wen`=0 and no read is recorded as issued.
  - All `stall_i`=1.
  - `prio` frozen.
  - An in-flight read still returns and is captured (see read return).
- **Memory outputs**
  - Combinational from the grant.
  - Ungranted port drives address/data 0 and `mem_wen`=0.
- **Read return tracking**
  - `rd_pend` (valid, owner) is set in the cycle a read issues.
  - Next cycle `mem_rdata` goes to the owner:
    - Return cycle: `rdata_owner` = `mem_rdata` (bypass), `rvalid_owner`=1.
    - If `stall_owner`=0 that cycle, the word is consumed and not held.
    - Otherwise it is written to `hold_owner`. `rvalid_owner` stays 1 with `rdata_owner` = `hold_owner` until the first cycle with `stall_owner`=0, inclusive; it clears after that cycle.
  - A new read issued in the consuming cycle returns next cycle normally.
  - `rdata_i` keeps its last value when `rvalid_i`=0.
- **Reset** (synchronous): `prio`=0, `rd_pend`=0, both hold registers 0, `rvalid_i`=0.
  - While `rst`=1: `stall_i`=1, `mem_wen`=0, `mem_raddr`=`mem_waddr`=`mem_wdata`=0.
  - Reset mid-read discards the return.

## Timing
- Issue cycle N: address on `mem_raddr` combinationally; `mem_rdata` is sampled at cycle N+1 (1-cycle RAM latency).
- Uncontended read: `rvalid_i` in cycle N+1, zero added latency.
- Write takes effect at the RAM on the clock edge of the issue cycle.
- Contention: the loser issues at the earliest the next cycle (round-robin bound: 1 lost cycle per conflict, absent `global_stall`).
- Same-cycle write and read to the same address by different requesters: the read returns the RAM's pre-write value (RAM behaviour, not corrected).

## Configuration
- `RAM_ARB_PERF_EN` defined:
  - Adds outputs `conflict_cnt_0`, `conflict_cnt_1` (16 bits each).
  - Each counts cycles where requester i was active, not issued, and `global_stall`=0.
  - Counters saturate at 16'hFFFF and reset to 0.
- Undefined: no counters, no ports; behaviour otherwise identical.

## Structure
- Package `ram_arb_pkg`: `ADDR_WIDTH`/`DATA_WIDTH` defaults, `req_id_t` (1-bit requester id), `rd_pend_t` struct {valid, owner}.
- One sub-module `ram_arb_grant`: combinational grant/issue computation from `prio`, the requests and `global_stall`. Pointer, return tracking and holds stay in the top.

## Test plan
- **Uncontended read:** RAM preloaded addr 1 = 10; requester 0 `ren_0`=1, `raddr_0`=1 for one cycle → `stall_0`=0, `rvalid_0`=1 next cycle with `rdata_0`=10.
- **Read/read conflict:** both read (addr 1 = 10, addr 2 = 20), `prio`=0 → `stall_1`=1 first cycle; `rdata_0`=10 at cycle 2; `rdata_1`=20 at cycle 3; `prio`=0 again afterwards.
- **Disjoint ports:** requester 0 writes 5 to addr 3 while requester 1 reads addr 1 → both issue same cycle, no stall; `rdata_1`=10; later read of addr 3 returns 5.
- **Return during global stall:** read addr 1 issued, then `global_stall`=1 for 3 cycles → `rvalid_0` stays 1 with `rdata_0`=10 throughout; clears the cycle after `global_stall` drops; `mem_wen`=0 while stalled.
- **Reset mid-read:** read issued, `rst`=1 next edge → `rvalid_0`=0, `stall_0`=1, `mem_wen`=0 during reset; no stale return after release.
- **`RAM_ARB_PERF_EN`:** 4 cycles of read/read conflict → `conflict_cnt_0`+`conflict_cnt_1`=2; cycles under `global_stall` not counted.
